// File: rtl/compositor_pkg.sv
// Shared types, defaults and helpers for the sprite compositor.
package compositor_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int COLOR_W_DEF = 8;

  // One pixel colour, one channel per field.
  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  // Rectangle geometry of one sprite; the covered area is (w+1) x (h+1).
  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] w;
    logic [COORD_W_DEF-1:0] h;
  } sprite_geom_t;

  // Flatten a colour struct into the {R,G,B} bus layout.
  function automatic logic [3*COLOR_W_DEF-1:0] rgb_pack(input rgb_t c);
    return {c.r, c.g, c.b};
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Combinational single-sprite coverage test with left-edge wrap support.
module sprite_hit #(
  parameter int COORD_W = 11,
  parameter int WRAP_X  = 680
) (
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  input  logic [COORD_W-1:0] spr_w,
  input  logic [COORD_W-1:0] spr_h,
  input  logic               en,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic               hit
);

  logic [COORD_W:0] x_end_s;
  logic [COORD_W:0] y_end_s;
  logic             wrapped_s;
  logic             x_in_s;
  logic             y_in_s;

  // Bounds test; ends carry an extra bit so right/bottom edges never wrap,
  // except that a wrapped sprite's span restarts at column 0.
  always_comb begin
    x_end_s   = {1'b0, spr_x} + {1'b0, spr_w};
    y_end_s   = {1'b0, spr_y} + {1'b0, spr_h};
    wrapped_s = (32'(spr_x) >= WRAP_X);
    y_in_s    = (draw_y >= spr_y) && ({1'b0, draw_y} <= y_end_s);
    if (wrapped_s) begin
      x_in_s = (draw_x <= x_end_s[COORD_W-1:0]);
    end else begin
      x_in_s = (draw_x >= spr_x) && ({1'b0, draw_x} <= x_end_s);
    end
    hit = en & x_in_s & y_in_s;
  end

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: shadowed geometry, register-loaded colours,
// 2-stage pipeline with lowest-index priority, per-frame player collisions.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int                   NUM_SPRITES = 8,
  parameter int                   COORD_W     = COORD_W_DEF,
  parameter int                   COLOR_W     = COLOR_W_DEF,
  parameter int                   WRAP_X      = 680,
  parameter logic [3*COLOR_W-1:0] BG_RGB      = 24'hFFFFFF,
  localparam int                  IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [NUM_SPRITES*COORD_W-1:0] SprX,
  input  logic [NUM_SPRITES*COORD_W-1:0] SprY,
  input  logic [NUM_SPRITES*COORD_W-1:0] SprW,
  input  logic [NUM_SPRITES*COORD_W-1:0] SprH,
  input  logic                           cfg_we,
  input  logic [IDX_W-1:0]               cfg_idx,
  input  logic [3*COLOR_W-1:0]           cfg_rgb,
  input  logic                           cfg_en,
  output logic [COLOR_W-1:0]             Red,
  output logic [COLOR_W-1:0]             Green,
  output logic [COLOR_W-1:0]             Blue,
  output logic                           rgb_valid,
  output logic                           hit_any,
  output logic [IDX_W-1:0]               hit_idx,
  output logic [NUM_SPRITES-1:0]         Collision
);

  logic [NUM_SPRITES*COORD_W-1:0] shx_r, shy_r, shw_r, shh_r;
  logic [3*COLOR_W-1:0]           color_r [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]         en_r;
  logic [NUM_SPRITES-1:0]         hit_s;
  logic [NUM_SPRITES-1:0]         coll_s;
  logic [NUM_SPRITES-1:0]         hit1_r;
  logic [NUM_SPRITES-1:0]         coll1_r;
  logic                           valid1_r;
  logic [NUM_SPRITES-1:0]         acc_r;
  logic [IDX_W-1:0]               win_s;
  logic                           any_s;
  logic [3*COLOR_W-1:0]           out_s;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit #(.COORD_W(COORD_W), .WRAP_X(WRAP_X)) u_hit (
      .spr_x  (shx_r[g*COORD_W +: COORD_W]),
      .spr_y  (shy_r[g*COORD_W +: COORD_W]),
      .spr_w  (shw_r[g*COORD_W +: COORD_W]),
      .spr_h  (shh_r[g*COORD_W +: COORD_W]),
      .en     (en_r[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .hit    (hit_s[g])
    );
  end

  // Geometry is latched only at frame start so a frame never tears.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      shx_r <= '0;
      shy_r <= '0;
      shw_r <= '0;
      shh_r <= '0;
    end else if (frame_start) begin
      shx_r <= SprX;
      shy_r <= SprY;
      shw_r <= SprW;
      shh_r <= SprH;
    end
  end

  // Colour/enable register file, written one sprite at a time.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      en_r <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        color_r[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_idx) < NUM_SPRITES)) begin
      color_r[cfg_idx] <= cfg_rgb;
      en_r[cfg_idx]    <= cfg_en;
    end
  end

  // Player-overlap qualifier: sprite 0 must hit on a valid pixel; bit 0 never reports.
  always_comb begin
    coll_s    = '0;
    if (pix_valid && hit_s[0]) begin
      coll_s = hit_s;
    end else begin
      coll_s = '0;
    end
    coll_s[0] = 1'b0;
  end

  // Stage 1: capture the hit vector, valid bit and collision qualifier.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hit1_r   <= '0;
      coll1_r  <= '0;
      valid1_r <= 1'b0;
    end else begin
      hit1_r   <= hit_s;
      coll1_r  <= coll_s;
      valid1_r <= pix_valid;
    end
  end

  // Priority encoder (lowest index wins) and colour select with blanking.
  always_comb begin
    win_s = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      win_s = hit1_r[i] ? IDX_W'(i) : win_s;
    end
    any_s = |hit1_r;
    if (!valid1_r) begin
      out_s = '0;
    end else if (any_s) begin
      out_s = color_r[win_s];
    end else begin
      out_s = BG_RGB;
    end
  end

  // Stage 2: registered pixel outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      rgb_valid <= 1'b0;
      hit_any   <= 1'b0;
      hit_idx   <= '0;
    end else begin
      Red       <= out_s[3*COLOR_W-1 -: COLOR_W];
      Green     <= out_s[2*COLOR_W-1 -: COLOR_W];
      Blue      <= out_s[COLOR_W-1 -: COLOR_W];
      rgb_valid <= valid1_r;
      hit_any   <= valid1_r & any_s;
      hit_idx   <= (valid1_r && any_s) ? win_s : '0;
    end
  end

  // Collision accumulator, published and cleared at each frame start.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      acc_r     <= '0;
      Collision <= '0;
    end else if (frame_start) begin
      Collision <= acc_r | coll1_r;
      acc_r     <= '0;
    end else begin
      acc_r     <= acc_r | coll1_r;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor.
module tb_sprite_compositor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        pix_valid;
  logic [10:0] DrawX, DrawY;
  logic [87:0] SprX, SprY, SprW, SprH;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [23:0] cfg_rgb;
  logic        cfg_en;
  logic [7:0]  Red, Green, Blue;
  logic        rgb_valid, hit_any;
  logic [2:0]  hit_idx;
  logic [7:0]  Collision;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [23:0] o_rgb;
  logic        o_any, o_rv;
  logic [2:0]  o_idx;

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .SprX(SprX), .SprY(SprY), .SprW(SprW), .SprH(SprH),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rgb(cfg_rgb), .cfg_en(cfg_en),
    .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid),
    .hit_any(hit_any), .hit_idx(hit_idx), .Collision(Collision)
  );

  always #5 Clk = ~Clk;

  task automatic set_geom(input int i, input int x, input int y, input int w, input int h);
    SprX[i*11 +: 11] = 11'(x);
    SprY[i*11 +: 11] = 11'(y);
    SprW[i*11 +: 11] = 11'(w);
    SprH[i*11 +: 11] = 11'(h);
  endtask

  task automatic cfg(input int i, input logic [23:0] rgb, input logic en);
    @(negedge Clk);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_rgb = rgb; cfg_en = en;
    @(negedge Clk);
    cfg_we = 1'b0;
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  // Presents one pixel and returns the outputs two clock edges later.
  task automatic pixel(input int x, input int y);
    @(negedge Clk);
    pix_valid = 1'b1; DrawX = 11'(x); DrawY = 11'(y);
    @(negedge Clk);
    pix_valid = 1'b0;
    @(negedge Clk);
    o_rgb = {Red, Green, Blue}; o_any = hit_any; o_idx = hit_idx; o_rv = rgb_valid;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({Red, Green, Blue, rgb_valid, hit_any, hit_idx, Collision} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rgb=%h v=%b any=%b idx=%0d coll=%b want all 0",
               {Red, Green, Blue}, rgb_valid, hit_any, hit_idx, Collision);
    end
    Reset = 1'b1;
    @(negedge Clk);
    pix_valid = 1'b1; DrawX = 11'd5; DrawY = 11'd5;
    @(negedge Clk);
    pix_valid = 1'b0;
    n_cmp++;
    if (rgb_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early rgb_valid=%b want 0", rgb_valid);
    end
    @(negedge Clk);
    n_cmp++;
    if ({rgb_valid, Red, Green, Blue, hit_any, hit_idx} !== {1'b1, 24'hFFFFFF, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL idle_bg got v=%b rgb=%h any=%b idx=%0d want v=1 rgb=ffffff any=0 idx=0",
               rgb_valid, {Red, Green, Blue}, hit_any, hit_idx);
    end
    @(negedge Clk);
    n_cmp++;
    if ({rgb_valid, Red, Green, Blue} !== 25'd0) begin
      n_fail++; $display("FAIL blanking got v=%b rgb=%h want 0", rgb_valid, {Red, Green, Blue});
    end
  endtask

  task automatic test_basic();
    logic [23:0] exp_rgb [3] = '{24'h3C8250, 24'h3C8250, 24'hFFFFFF};
    int          xs [3] = '{100, 110, 111};
    int          ys [3] = '{50, 60, 60};
    logic        exp_any [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0]  exp_idx [3] = '{3'd2, 3'd2, 3'd0};
    cfg(2, 24'h3C8250, 1'b1);
    set_geom(2, 100, 50, 10, 10);
    frame();
    for (int k = 0; k < 3; k++) begin
      pixel(xs[k], ys[k]);
      n_cmp++;
      if ({o_rv, o_rgb, o_any, o_idx} !== {1'b1, exp_rgb[k], exp_any[k], exp_idx[k]}) begin
        n_fail++;
        $display("FAIL basic_hit(%0d,%0d) got v=%b rgb=%h any=%b idx=%0d want rgb=%h any=%b idx=%0d",
                 xs[k], ys[k], o_rv, o_rgb, o_any, o_idx, exp_rgb[k], exp_any[k], exp_idx[k]);
      end
    end
  endtask

  task automatic test_wrap();
    cfg(1, 24'h112233, 1'b1);
    set_geom(1, 2040, 0, 20, 100);
    frame();
    for (int x = 0; x <= 13; x++) begin
      pixel(x, 10);
      n_cmp++;
      if (x <= 12 && {o_any, o_idx, o_rgb} !== {1'b1, 3'd1, 24'h112233}) begin
        n_fail++; $display("FAIL wrap_hit x=%0d got any=%b idx=%0d rgb=%h want 1/1/112233", x, o_any, o_idx, o_rgb);
      end else if (x == 13 && {o_any, o_rgb} !== {1'b0, 24'hFFFFFF}) begin
        n_fail++; $display("FAIL wrap_edge x=13 got any=%b rgb=%h want 0/ffffff", o_any, o_rgb);
      end
    end
    pixel(2040, 10);
    n_cmp++;
    if ({o_any, o_rgb} !== {1'b0, 24'hFFFFFF}) begin
      n_fail++; $display("FAIL wrap_origin x=2040 got any=%b rgb=%h want 0/ffffff", o_any, o_rgb);
    end
  endtask

  task automatic test_priority_enable();
    cfg(3, 24'h445566, 1'b1);
    set_geom(1, 190, 190, 20, 20);
    set_geom(3, 195, 195, 10, 10);
    frame();
    pixel(200, 200);
    n_cmp++;
    if ({o_any, o_idx, o_rgb} !== {1'b1, 3'd1, 24'h112233}) begin
      n_fail++; $display("FAIL priority got any=%b idx=%0d rgb=%h want 1/1/112233", o_any, o_idx, o_rgb);
    end
    cfg(1, 24'h112233, 1'b0);
    pixel(200, 200);
    n_cmp++;
    if ({o_any, o_idx, o_rgb} !== {1'b1, 3'd3, 24'h445566}) begin
      n_fail++; $display("FAIL disable got any=%b idx=%0d rgb=%h want 1/3/445566", o_any, o_idx, o_rgb);
    end
  endtask

  task automatic test_shadow();
    set_geom(3, 400, 195, 10, 10);
    pixel(200, 200);
    n_cmp++;
    if (o_idx !== 3'd3 || o_any !== 1'b1) begin
      n_fail++; $display("FAIL shadow_old got any=%b idx=%0d want 1/3", o_any, o_idx);
    end
    pixel(405, 200);
    n_cmp++;
    if (o_any !== 1'b0) begin
      n_fail++; $display("FAIL shadow_new_early got any=%b want 0", o_any);
    end
    @(negedge Clk);
    frame_start = 1'b1; pix_valid = 1'b1; DrawX = 11'd200; DrawY = 11'd200;
    @(negedge Clk);
    frame_start = 1'b0; pix_valid = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({hit_any, hit_idx} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL shadow_coincident got any=%b idx=%0d want 1/3", hit_any, hit_idx);
    end
    pixel(200, 200);
    n_cmp++;
    if ({o_any, o_rgb} !== {1'b0, 24'hFFFFFF}) begin
      n_fail++; $display("FAIL shadow_moved_old got any=%b rgb=%h want 0/ffffff", o_any, o_rgb);
    end
    pixel(405, 200);
    n_cmp++;
    if ({o_any, o_idx} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL shadow_moved_new got any=%b idx=%0d want 1/3", o_any, o_idx);
    end
  endtask

  task automatic test_collision();
    cfg(0, 24'h0A0B0C, 1'b1);
    cfg(4, 24'h778899, 1'b1);
    set_geom(0, 500, 300, 5, 5);
    set_geom(4, 505, 305, 10, 10);
    frame();
    n_cmp++;
    if (Collision !== 8'h00) begin
      n_fail++; $display("FAIL coll_initial got %b want 00000000", Collision);
    end
    pixel(500, 300);
    pixel(505, 305);
    n_cmp++;
    if ({o_any, o_idx, o_rgb} !== {1'b1, 3'd0, 24'h0A0B0C}) begin
      n_fail++; $display("FAIL coll_pixel got any=%b idx=%0d rgb=%h want 1/0/0a0b0c", o_any, o_idx, o_rgb);
    end
    frame();
    n_cmp++;
    if (Collision !== 8'b0001_0000) begin
      n_fail++; $display("FAIL coll_report got %b want 00010000", Collision);
    end
    pixel(520, 320);
    n_cmp++;
    if (Collision !== 8'b0001_0000) begin
      n_fail++; $display("FAIL coll_hold got %b want 00010000", Collision);
    end
    frame();
    n_cmp++;
    if (Collision !== 8'h00) begin
      n_fail++; $display("FAIL coll_clear got %b want 00000000", Collision);
    end
  endtask

  task automatic test_reset_flush();
    pixel(505, 305);
    frame();
    @(negedge Clk);
    pix_valid = 1'b1; DrawX = 11'd505; DrawY = 11'd305;
    @(negedge Clk);
    pix_valid = 1'b0; Reset = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({rgb_valid, Red, Green, Blue, hit_any, Collision} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_flush got v=%b rgb=%h any=%b coll=%b want 0",
               rgb_valid, {Red, Green, Blue}, hit_any, Collision);
    end
    Reset = 1'b1;
    pixel(505, 305);
    n_cmp++;
    if ({o_any, o_rgb} !== {1'b0, 24'hFFFFFF}) begin
      n_fail++; $display("FAIL reset_cfg_clear got any=%b rgb=%h want 0/ffffff", o_any, o_rgb);
    end
  endtask

  initial begin
    Reset = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    DrawX = 11'd0; DrawY = 11'd0;
    SprX = 88'd0; SprY = 88'd0; SprW = 88'd0; SprH = 88'd0;
    cfg_we = 1'b0; cfg_idx = 3'd0; cfg_rgb = 24'd0; cfg_en = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_priority_enable();
    test_shadow();
    test_collision();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised per-pixel colour compositor for the VGA path; generalises the fixed frog/car/lilypad mapper to NUM_SPRITES rectangular sprites.
- Adds register-loaded per-sprite colours and enables, frame-synchronous position shadowing to prevent tearing, a 2-stage pipeline, and a per-frame player-collision report.
- Sits between the motion modules and the VGA controller: DrawX/DrawY in, Red/Green/Blue out.

Parameters:
- NUM_SPRITES, 8: sprite count. Sprite 0 is the player.
- COORD_W, 11: coordinate width.
- COLOR_W, 8: bits per colour channel.
- WRAP_X, 680: an X value >= WRAP_X marks a sprite as wrapped off the left edge.
- BG_RGB, 24'hFFFFFF: background colour {R,G,B}.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  DrawX/DrawY are a visible pixel this cycle.
- DrawX, DrawY  in  COORD_W each  current pixel.
- SprX, SprY, SprW, SprH  in  NUM_SPRITES*COORD_W each  packed live geometry; sprite i occupies slice [i*COORD_W +: COORD_W].
- cfg_we  in  1  colour/enable write strobe.
- cfg_idx  in  $clog2(NUM_SPRITES)  target sprite.
- cfg_rgb  in  3*COLOR_W  {R,G,B} colour for the target sprite.
- cfg_en  in  1  enable for the target sprite.
- Red, Green, Blue  out  COLOR_W each  composited pixel.
- rgb_valid  out  1  pix_valid delayed 2 cycles.
- hit_any  out  1  some sprite covers the output pixel.
- hit_idx  out  $clog2(NUM_SPRITES)  winning sprite; 0 when hit_any=0.
- Collision  out  NUM_SPRITES  bit i=1: sprite 0 overlapped sprite i during the previous frame; bit 0 is always 0.

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - Shadow geometry, colours, enables, collision accumulator and Collision clear to 0.
  - Red/Green/Blue, rgb_valid, hit_any and hit_idx clear to 0.
  - Both pipeline stages flush; reset mid-frame discards in-flight pixels.
- Shadowing:
  - On frame_start, SprX/Y/W/H are copied into shadow registers.
  - All hit tests use shadow values only.
  - A pixel presented in the same cycle as frame_start is tested against the old shadow.
- Config writes:
  - cfg_we=1 writes colour[cfg_idx] and en[cfg_idx] at the clock edge.
  - The new value is visible to stage 2 from the next cycle.
  - cfg_we is independent of frame_start; both may occur in one cycle.
- Hit rule for sprite i (inclusive bounds, so W+1 by H+1 pixels):
  - Y: SprY <= DrawY <= SprY+SprH, computed in COORD_W+1 bits; no vertical wrap.
  - X, non-wrapped (SprX < WRAP_X): SprX <= DrawX <= SprX+SprW, computed in COORD_W+1 bits.
  - X, wrapped (SprX >= WRAP_X): DrawX <= (SprX+SprW) mod 2^COORD_W; the span starts at column 0.
  - en[i]=0: never hits.
- Stage 1 (cycle N+1): registers the hit vector[NUM_SPRITES], the pixel's pix_valid, and the collision qualifier.
- Stage 2 (cycle N+2):
  - Priority: lowest set index wins.
  - Output is colour[winner], or BG_RGB if no sprite hits.
  - If the stage-2 valid bit is 0, Red/Green/Blue are forced to 0 (blanking) and hit_any=0.
  - rgb_valid follows the stage-2 valid bit.
- Latency: exactly 2 cycles from pix_valid/DrawX to Red/Green/Blue; throughput 1 pixel/cycle; no stalls.
- Collision:
  - For i>=1: acc[i] is set when the stage-1 pixel is valid and hit[0] & hit[i].
  - On frame_start: Collision <= acc, including any bit set that same cycle; acc <= 0.
  - Collision otherwise holds.
  - Sprite 0 disabled: no collisions accumulate.

Decomposition:
- compositor_pkg holds:
  - COORD_W and COLOR_W defaults.
  - typedef rgb_t: struct of R/G/B at COLOR_W.
  - typedef sprite_geom_t: x, y, w, h.
  - function rgb_pack.
- Sub-module sprite_hit: purely combinational single-sprite test (shadow geometry, enable, DrawX/DrawY, WRAP_X → hit); generate-instantiated NUM_SPRITES times.
- The top level holds the shadow registers, colour/enable registers, pipeline, priority encoder and collision logic.

Test Plan:
- Reset then idle:
  - Stimulus: Reset=0 for 2 cycles, then pix_valid pulses.
  - Required: all outputs 0; with no sprites enabled, outputs show BG FF/FF/FF with rgb_valid exactly 2 cycles after pix_valid.
- Basic hit and latency:
  - Stimulus: sprite 2 enabled, colour 3C/82/50, X=100, Y=50, W=H=10, shadowed by frame_start; pixels (100,50), (110,60), (111,60).
  - Required: first two output 3C/82/50 with hit_idx=2 at N+2; the third outputs BG.
- Wrap-around:
  - Stimulus: sprite 1 with X=2040 (>=680), W=20.
  - Required: DrawX=0..12 hit, DrawX=13 misses, DrawX=2040 misses.
- Priority and enable:
  - Stimulus: sprites 1 and 3 overlap at (200,200).
  - Required: hit_idx=1; after cfg_we disables sprite 1, hit_idx=3 from the next pixel onward.
- Shadowing:
  - Stimulus: SprX changes mid-frame.
  - Required: output unchanged until after the next frame_start; a pixel coinciding with frame_start uses the old position.
- Collision:
  - Stimulus: sprite 0 overlaps sprite 4 for one pixel in frame k.
  - Required: Collision=8'b0001_0000 after frame_start k+1; back to 0 after frame_start k+2 with no overlap.
